// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg
// Shared definitions for the gate BIST controller: data widths, the
// sequencer state encoding, polynomial tap positions and the LFSR/MISR
// next-state helpers used by both the top level and the MISR sub-module.
//
// Contents:
//   PAT_W, RSP_W            pattern / response widths
//   bist_state_e            IDLE, SETTLE, CAPTURE, DONE
//   LFSR_TAP_*, MISR_TAP_*  feedback tap bit positions
//   lfsr_next(), misr_next() one-step next-state functions
package gate_bist_pkg;

    localparam int PAT_W = 15;
    localparam int RSP_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } bist_state_e;

    // x^15 + x^14 + 1 (Fibonacci form, maximal length)
    localparam int LFSR_TAP_HI = 14;
    localparam int LFSR_TAP_LO = 13;

    // x^10 + x^7 + 1
    localparam int MISR_TAP_HI = 9;
    localparam int MISR_TAP_LO = 6;

    // Shift left, feedback bit enters at bit 0.
    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] p);
        return {p[PAT_W-2:0], p[LFSR_TAP_HI] ^ p[LFSR_TAP_LO]};
    endfunction

    // Same shift structure as the LFSR, with the response folded in.
    function automatic logic [RSP_W-1:0] misr_next(input logic [RSP_W-1:0] s,
                                                   input logic [RSP_W-1:0] r);
        return {s[RSP_W-2:0], s[MISR_TAP_HI] ^ s[MISR_TAP_LO]} ^ r;
    endfunction

endpackage

// File: rtl/gate_bist_misr.sv
// gate_bist_misr
// Multiple-input signature register that compacts the gate-model
// responses. Clear has priority over enable.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (clears the signature)
//   clr_i  in   synchronous clear to zero
//   en_i   in   fold rsp_i into the signature on this edge
//   rsp_i  in   RSP_W-bit gate-model response
//   sig_o  out  current signature
module gate_bist_misr
    import gate_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [RSP_W-1:0] rsp_i,
    output logic [RSP_W-1:0] sig_o
);

    logic [RSP_W-1:0] sig_q;
    logic [RSP_W-1:0] sig_d;

    // Next signature: clear at run start, compact on capture, else hold.
    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = misr_next(sig_q, rsp_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl
// BIST harness around a combinational gate model. An LFSR drives the
// PAT_W primary inputs; each pattern is held for SETTLE_CYC cycles, then
// the RSP_W responses are folded into a MISR in a one-cycle CAPTURE
// state. After NUM_PATTERNS captures the signature is compared against
// golden_i and the result is held on pass_o.
//
// Optional feature macro: GATE_BIST_ABORT_EN
//   adds abort_i (cancel a run in SETTLE/CAPTURE) and aborted_o (pulse).
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start_i      in   begin a run (only honoured in IDLE)
//   golden_i     in   expected signature, sampled in DONE
//   rsp_i        in   gate-model outputs, sampled at CAPTURE edges
//   pat_o        out  registered gate-model inputs
//   busy_o       out  high in SETTLE and CAPTURE
//   done_o       out  one-cycle end-of-run pulse
//   pass_o       out  signature matched golden_i in the last run
//   signature_o  out  current MISR contents
//   pat_cnt_o    out  patterns captured in the current run
//   abort_i      in   (GATE_BIST_ABORT_EN only) cancel current run
//   aborted_o    out  (GATE_BIST_ABORT_EN only) one-cycle abort pulse
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned      NUM_PATTERNS = 256,
    parameter int unsigned      SETTLE_CYC   = 2,
    parameter logic [PAT_W-1:0] LFSR_SEED    = 15'h0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [RSP_W-1:0] golden_i,
    input  logic [RSP_W-1:0] rsp_i,
`ifdef GATE_BIST_ABORT_EN
    input  logic             abort_i,
    output logic             aborted_o,
`endif
    output logic [PAT_W-1:0] pat_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [RSP_W-1:0] signature_o,
    output logic [15:0]      pat_cnt_o
);

    localparam int unsigned      SET_W         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_RELOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [15:0]      LAST_PAT      = 16'(NUM_PATTERNS - 1);

    bist_state_e      state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             misr_clr;
    logic             misr_en;
`ifdef GATE_BIST_ABORT_EN
    logic             aborted_q, aborted_d;
`endif

    // Sequencer: every pattern costs SETTLE_CYC cycles in SETTLE plus one
    // in CAPTURE. The LFSR only advances when another pattern follows, so
    // pat_o keeps the last pattern through DONE and IDLE.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
`ifdef GATE_BIST_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    pat_d    = LFSR_SEED;
                    misr_clr = 1'b1;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    settle_d = SETTLE_RELOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            CAPTURE: begin
                misr_en = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == LAST_PAT) begin
                    state_d = DONE;
                end else begin
                    pat_d    = lfsr_next(pat_q);
                    settle_d = SETTLE_RELOAD;
                    state_d  = SETTLE;
                end
            end
            DONE: begin
                pass_d  = (signature_o == golden_i);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef GATE_BIST_ABORT_EN
        // Abort overrides everything above, including CAPTURE->DONE:
        // no capture, counters and pattern freeze where they are.
        if (abort_i && (state_q == SETTLE || state_q == CAPTURE)) begin
            state_d   = IDLE;
            settle_d  = settle_q;
            pat_d     = pat_q;
            cnt_d     = cnt_q;
            misr_en   = 1'b0;
            aborted_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            pat_q    <= '0;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
        end
    end

`ifdef GATE_BIST_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted_o = aborted_q;
`endif

    gate_bist_misr u_misr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (misr_clr),
        .en_i  (misr_en),
        .rsp_i (rsp_i),
        .sig_o (signature_o)
    );

    assign pat_o     = pat_q;
    assign pat_cnt_o = cnt_q;
    assign pass_o    = pass_q;
    assign busy_o    = (state_q == SETTLE) || (state_q == CAPTURE);
    assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl
// Directed bench for gate_bist_ctrl. Instance A uses a short run
// (4 patterns, 1 settle cycle) for timing, signature, restart, reset and
// abort scenarios; instance B uses the full 32767-pattern run to check
// the LFSR period. Define GATE_BIST_ABORT_EN to exercise the abort port.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;

    logic             startA = 1'b0;
    logic [RSP_W-1:0] rspA   = '0;
    logic [RSP_W-1:0] goldA  = '0;
    logic [PAT_W-1:0] patA;
    logic             busyA, doneA, passA;
    logic [RSP_W-1:0] sigA;
    logic [15:0]      cntA;

    logic             startB = 1'b0;
    logic [RSP_W-1:0] rspB   = '0;
    logic [RSP_W-1:0] goldB  = '0;
    logic [PAT_W-1:0] patB;
    logic             busyB, doneB, passB;
    logic [RSP_W-1:0] sigB;
    logic [15:0]      cntB;

`ifdef GATE_BIST_ABORT_EN
    logic abortA = 1'b0;
    logic abortB = 1'b0;
    logic abortedA, abortedB;
`endif

    int vecCount = 0;
    int errCount = 0;

    logic [PAT_W-1:0] expPat [4] = '{15'h0001, 15'h0002, 15'h0004, 15'h0008};
    logic [RSP_W-1:0] expSig [4];

    bit seen [0:32767];

    always #5 clk = ~clk;

    gate_bist_ctrl #(.NUM_PATTERNS(4), .SETTLE_CYC(1), .LFSR_SEED(15'h0001)) dutA (
        .clk         (clk),
        .rst         (rst),
        .start_i     (startA),
        .golden_i    (goldA),
        .rsp_i       (rspA),
`ifdef GATE_BIST_ABORT_EN
        .abort_i     (abortA),
        .aborted_o   (abortedA),
`endif
        .pat_o       (patA),
        .busy_o      (busyA),
        .done_o      (doneA),
        .pass_o      (passA),
        .signature_o (sigA),
        .pat_cnt_o   (cntA)
    );

    gate_bist_ctrl #(.NUM_PATTERNS(32767), .SETTLE_CYC(1), .LFSR_SEED(15'h0001)) dutB (
        .clk         (clk),
        .rst         (rst),
        .start_i     (startB),
        .golden_i    (goldB),
        .rsp_i       (rspB),
`ifdef GATE_BIST_ABORT_EN
        .abort_i     (abortB),
        .aborted_o   (abortedB),
`endif
        .pat_o       (patB),
        .busy_o      (busyB),
        .done_o      (doneB),
        .pass_o      (passB),
        .signature_o (sigB),
        .pat_cnt_o   (cntB)
    );

    // Independent reference for x^15+x^14+1, used only for the wrap check.
    function automatic logic [14:0] refLfsr(input logic [14:0] p);
        return {p[13:0], p[14] ^ p[13]};
    endfunction

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on instance A; returns 1 ns after edge 0.
    task automatic applyStimulus(input logic [RSP_W-1:0] rsp, input logic [RSP_W-1:0] gold);
        rspA   = rsp;
        goldA  = gold;
        startA = 1'b1;
        step(1);
        startA = 1'b0;
    endtask

    // Walk a 4-pattern run of instance A from edge 0 to the cycle after DONE.
    task automatic runPatternsA(input logic expPass);
        checkOutput("passClearedAtStart", passA, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("pat%0d", i), patA, expPat[i]);
            checkOutput($sformatf("busy%0d", i), busyA, 1'b1);
            step(1);
            checkOutput($sformatf("noEarlyDone%0d", i), doneA, 1'b0);
            step(1);
            checkOutput($sformatf("sig%0d", i), sigA, expSig[i]);
            checkOutput($sformatf("cnt%0d", i), cntA, i + 1);
        end
        checkOutput("doneAfterEdge8", doneA, 1'b1);
        checkOutput("patHoldInDone", patA, 15'h0008);
        step(1);
        checkOutput("donePulseEnds", doneA, 1'b0);
        checkOutput("idleNotBusy", busyA, 1'b0);
        checkOutput("passResult", passA, expPass);
    endtask

    initial begin
        int repeats;
        int zeros;
        logic [PAT_W-1:0] lastPat;

        // Reset state
        #1 rst = 1'b1;
        #2;
        checkOutput("rstPat", patA, 15'h0);
        checkOutput("rstBusy", busyA, 1'b0);
        checkOutput("rstDone", doneA, 1'b0);
        checkOutput("rstPass", passA, 1'b0);
        checkOutput("rstSig", sigA, 10'h0);
        checkOutput("rstCnt", cntA, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1);

        // Zero responses, golden zero
        $display("[TB] run 1: rsp=0 golden=0");
        expSig = '{10'h000, 10'h000, 10'h000, 10'h000};
        applyStimulus(10'h000, 10'h000);
        runPatternsA(1'b1);

        // Constant response 001, matching golden
        $display("[TB] run 2: rsp=001 golden=00F");
        expSig = '{10'h001, 10'h003, 10'h007, 10'h00F};
        applyStimulus(10'h001, 10'h00F);
        runPatternsA(1'b1);

        // Same responses, wrong golden
        $display("[TB] run 3: rsp=001 golden=00E");
        applyStimulus(10'h001, 10'h00E);
        runPatternsA(1'b0);

        // Start re-pulsed mid-run is ignored
        $display("[TB] start re-pulse during run");
        applyStimulus(10'h000, 10'h000);
        step(2);
        startA = 1'b1;
        step(1);
        startA = 1'b0;
        checkOutput("noRestartPat", patA, 15'h0002);
        step(5);
        checkOutput("repulseDoneEdge8", doneA, 1'b1);
        checkOutput("repulseCnt", cntA, 16'd4);
        step(1);

        // Start held high: back-to-back runs
        $display("[TB] start held high");
        startA = 1'b1;
        step(9);
        checkOutput("heldDone", doneA, 1'b1);
        step(1);
        checkOutput("heldIdlePass", passA, 1'b1);
        checkOutput("heldIdleBusy", busyA, 1'b0);
        step(1);
        startA = 1'b0;
        checkOutput("heldRestartBusy", busyA, 1'b1);
        checkOutput("heldRestartPat", patA, 15'h0001);
        checkOutput("heldRestartPassClr", passA, 1'b0);
        checkOutput("heldRestartCnt", cntA, 16'd0);
        step(9);

        // Asynchronous reset during SETTLE of pattern 2
        $display("[TB] async reset mid-run");
        applyStimulus(10'h001, 10'h000);
        step(2);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstPat", patA, 15'h0);
        checkOutput("asyncRstBusy", busyA, 1'b0);
        checkOutput("asyncRstSig", sigA, 10'h0);
        checkOutput("asyncRstCnt", cntA, 16'h0);
        checkOutput("asyncRstDone", doneA, 1'b0);
        step(1);
        rst = 1'b0;
        step(10);
        checkOutput("noDoneAfterRst", doneA, 1'b0);
        applyStimulus(10'h000, 10'h000);
        checkOutput("postRstPat0", patA, 15'h0001);
        step(2);
        checkOutput("postRstPat1", patA, 15'h0002);
        step(7);

`ifdef GATE_BIST_ABORT_EN
        // Abort in SETTLE of pattern 3
        $display("[TB] abort at cycle 5");
        applyStimulus(10'h001, 10'h000);
        step(4);
        abortA = 1'b1;
        step(1);
        abortA = 1'b0;
        checkOutput("abortedPulse", abortedA, 1'b1);
        checkOutput("abortIdle", busyA, 1'b0);
        checkOutput("abortCnt", cntA, 16'd2);
        checkOutput("abortSig", sigA, 10'h003);
        checkOutput("abortNoDone", doneA, 1'b0);
        step(1);
        checkOutput("abortedPulseEnds", abortedA, 1'b0);
        step(10);
        checkOutput("abortNoLateDone", doneA, 1'b0);
        checkOutput("abortPassLow", passA, 1'b0);
        checkOutput("abortCntFrozen", cntA, 16'd2);
`endif

        // LFSR period on the full-length instance
        $display("[TB] LFSR period run");
        repeats = 0;
        zeros   = 0;
        lastPat = '0;
        startB  = 1'b1;
        step(1);
        startB  = 1'b0;
        for (int n = 0; n < 32767; n++) begin
            if (patB == '0) zeros++;
            if (seen[patB]) repeats++;
            seen[patB] = 1'b1;
            lastPat = patB;
            step(2);
        end
        checkOutput("periodDone", doneB, 1'b1);
        checkOutput("periodCnt", cntB, 16'd32767);
        checkOutput("periodRepeats", repeats, 0);
        checkOutput("periodZeros", zeros, 0);
        checkOutput("periodWrap", refLfsr(lastPat), 15'h0001);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Self-test harness that sits around one combinational gate model: upstream it drives the 15 primary inputs, downstream it consumes the 10 primary outputs.
- A maximal-length LFSR generates input patterns; for each pattern it waits a settle window, then folds the responses into a MISR.
- At the end of a run, the final signature is compared with a golden value and pass/fail is reported.

Parameters:
- PAT_W, 15: pattern width; bit 0 drives N1, bit 14 drives N15.
- RSP_W, 10: response width; bits 0..9 = N484, N485, N491, N507, N510, N511, N512, N513, N514, N515.
- NUM_PATTERNS, 256: patterns per run; range 1..32767.
- SETTLE_CYC, 2: cycles a pattern is held before capture; must be ≥1.
- LFSR_SEED, 15'h0001: first pattern of every run; must be nonzero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  begins a run when sampled high in IDLE; ignored otherwise.
- golden_i  in  RSP_W  expected signature; sampled in the DONE state.
- rsp_i  in  RSP_W  gate-model outputs.
- pat_o  out  PAT_W  gate-model inputs; registered.
- busy_o  out  1  high in SETTLE and CAPTURE.
- done_o  out  1  one-cycle pulse at end of run.
- pass_o  out  1  signature == golden_i; valid from done_o until next start.
- signature_o  out  RSP_W  current MISR contents.
- pat_cnt_o  out  16  number of patterns captured in the current run.

Behaviour:
- Reset values: all outputs 0; pat_o=0, signature_o=0, state=IDLE, settle counter=0. Reset mid-run aborts immediately with no done_o.
- LFSR next-state (Fibonacci, x^15+x^14+1): p' = {p[13:0], p[14]^p[13]}.
- MISR next-state (x^10+x^7+1): s' = {s[8:0], s[9]^s[6]} ^ rsp_i.
- IDLE: busy_o=0; pat_o and signature_o hold.
  - On start_i: pat_o<=LFSR_SEED, signature<=0, pat_cnt<=0, pass_o<=0, settle cnt<=SETTLE_CYC-1; go to SETTLE.
- SETTLE: pat_o stable. If settle cnt==0, go to CAPTURE; else decrement.
- CAPTURE (one cycle): at its closing edge, signature<=MISR(signature, rsp_i) and pat_cnt<=pat_cnt+1.
  - If pat_cnt==NUM_PATTERNS-1: go to DONE; pat_o holds.
  - Else: pat_o<=LFSR(pat_o), settle cnt reloads, go to SETTLE.
- DONE (one cycle): done_o=1, pass_o<=(signature==golden_i), go to IDLE. pass_o is visible from the cycle after the done_o pulse.
- Timing:
  - Each pattern occupies exactly SETTLE_CYC+1 cycles.
  - With the edge that samples start_i as edge 0, done_o is high in the cycle after edge NUM_PATTERNS*(SETTLE_CYC+1).
- Boundaries and corner cases:
  - start_i high during busy or DONE: ignored; no restart, no queueing.
  - start_i held high continuously: a new run begins in the IDLE cycle following DONE.
  - NUM_PATTERNS=1: exactly one capture.
  - pat_cnt_o does not wrap (16 bits > 32767).
  - rsp_i is sampled only at CAPTURE edges; changes during SETTLE have no effect.

Optional Feature:
- Macro: GATE_BIST_ABORT_EN.
- Defined:
  - Adds input abort_i and output aborted_o.
  - abort_i high in SETTLE or CAPTURE forces IDLE at the next edge; that capture is not performed.
  - done_o stays 0, pass_o stays 0, aborted_o pulses one cycle, signature_o and pat_cnt_o freeze.
  - abort_i has priority over the CAPTURE→DONE transition.
- Undefined: neither port exists; behaviour is exactly as above.

Decomposition:
- Package gate_bist_pkg holds:
  - state enum {IDLE, SETTLE, CAPTURE, DONE};
  - LFSR/MISR tap constants;
  - functions lfsr_next() and misr_next().
- One sub-module: gate_bist_misr (RSP_W-bit register with clear, enable, and rsp_i input).
- Sequencer and LFSR stay in the top module.

Test Plan:
- NUM_PATTERNS=4, SETTLE_CYC=1, rsp_i=0, golden_i=0, start pulse:
  - pat_o sequence 0001, 0002, 0004, 0008;
  - done_o after edge 8; signature_o=000; pass_o=1.
- Same configuration, rsp_i held at 10'h001, golden_i=10'h00F:
  - intermediate signatures 001, 003, 007, 00F; pass_o=1.
  - Rerun with golden_i=10'h00E: pass_o=0.
- LFSR period check, NUM_PATTERNS=32767, rsp_i=0:
  - no pattern repeats; pattern 32768 would equal 0001 (checked via the next-state function); pat_o is never 0.
- start_i re-pulsed at cycle 3 of a run:
  - no restart; done_o still after edge 8.
  - start_i held high: second run starts the cycle after DONE, with pass_o cleared.
- rst asserted asynchronously mid-SETTLE of pattern 2:
  - all outputs 0 immediately, no done_o;
  - the next start reproduces pattern sequence 0001, 0002, ...
- GATE_BIST_ABORT_EN defined, abort_i at cycle 5:
  - aborted_o pulse; done_o never asserts; pat_cnt_o frozen at 2; state IDLE.
